// File: rtl/field_pack_pkg.sv
// -----------------------------------------------------------------------------
// field_pack_pkg
// Shared types and geometry for the 5-bit-field to 8-bit-byte pack datapath.
//   pack_state_t : sequencer state (collecting fields / emitting bytes)
//   NFIELDS      : fields per frame
//   FIELD_W      : width of one input field
//   BYTE_W       : width of one output byte
//   WORD_W       : width of the packed word (NFIELDS*FIELD_W + 2-bit tag)
// -----------------------------------------------------------------------------
package field_pack_pkg;

    typedef enum logic {COLLECT, EMIT} pack_state_t;

    localparam int NFIELDS = 6;
    localparam int FIELD_W = 5;
    localparam int BYTE_W  = 8;
    localparam int WORD_W  = 32;

endpackage

// File: rtl/pack_word_split.sv
// -----------------------------------------------------------------------------
// pack_word_split
// Combinational packer: concatenates six fields and a 2-bit tag into the word
// {a,b,c,d,e,f,tag} and splits it into four bytes, MSB first.
//   f_a..f_f : input fields, f_a lands in the most significant bits
//   tag      : constant appended as word[1:0]
//   byte_w   : word[31:24]
//   byte_x   : word[23:16]
//   byte_y   : word[15:8]
//   byte_z   : word[7:0]
// -----------------------------------------------------------------------------
module pack_word_split
    import field_pack_pkg::*;
(
    input  logic [FIELD_W-1:0] f_a,
    input  logic [FIELD_W-1:0] f_b,
    input  logic [FIELD_W-1:0] f_c,
    input  logic [FIELD_W-1:0] f_d,
    input  logic [FIELD_W-1:0] f_e,
    input  logic [FIELD_W-1:0] f_f,
    input  logic [1:0]         tag,
    output logic [BYTE_W-1:0]  byte_w,
    output logic [BYTE_W-1:0]  byte_x,
    output logic [BYTE_W-1:0]  byte_y,
    output logic [BYTE_W-1:0]  byte_z
);

    logic [WORD_W-1:0] word;

    assign word   = {f_a, f_b, f_c, f_d, f_e, f_f, tag};
    assign byte_w = word[31:24];
    assign byte_x = word[23:16];
    assign byte_y = word[15:8];
    assign byte_z = word[7:0];

endmodule

// File: rtl/field_pack_sequencer.sv
// -----------------------------------------------------------------------------
// field_pack_sequencer
// Collects six 5-bit fields over a valid/ready handshake, packs them with a
// 2-bit tag into a 32-bit word and emits that word as four bytes (MSB first)
// over a second valid/ready handshake.
//   clk         : system clock, rising edge
//   resetn      : asynchronous active-low reset
//   clr         : synchronous abort of the partial / in-flight frame
//   in_valid    : in_field valid
//   in_field    : field value, first accepted field is the MSB field
//   in_ready    : block can accept a field (state only)
//   out_valid   : out_byte valid
//   out_byte    : current byte of the packed word
//   out_idx     : byte index 0..3 (w,x,y,z)
//   out_last    : high with the z byte
//   out_ready   : consumer accepts out_byte
//   frames_done : count of fully emitted frames, wraps
//   busy        : partial frame held or frame being emitted
// -----------------------------------------------------------------------------
module field_pack_sequencer
    import field_pack_pkg::*;
#(
    parameter logic [1:0] TAG   = 2'b11,
    parameter int         CNT_W = 8
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               clr,
    input  logic               in_valid,
    input  logic [FIELD_W-1:0] in_field,
    output logic               in_ready,
    output logic               out_valid,
    output logic [BYTE_W-1:0]  out_byte,
    output logic [1:0]         out_idx,
    output logic               out_last,
    input  logic               out_ready,
    output logic [CNT_W-1:0]   frames_done,
    output logic               busy
);

    localparam int SR_W = (NFIELDS - 1) * FIELD_W;

    pack_state_t          state_q, state_d;
    logic [2:0]           field_cnt_q, field_cnt_d;
    logic [SR_W-1:0]      sr_q, sr_d;
    logic [WORD_W-1:0]    word_q, word_d;
    logic                 out_valid_q, out_valid_d;
    logic [1:0]           out_idx_q, out_idx_d;
    logic [CNT_W-1:0]     frames_done_q, frames_done_d;

    logic [BYTE_W-1:0]    byte_w, byte_x, byte_y, byte_z;

    // The shift register always holds the five most recent fields, so on the
    // sixth accept it plus the live in_field form the complete frame.
    pack_word_split u_split (
        .f_a    (sr_q[24:20]),
        .f_b    (sr_q[19:15]),
        .f_c    (sr_q[14:10]),
        .f_d    (sr_q[9:5]),
        .f_e    (sr_q[4:0]),
        .f_f    (in_field),
        .tag    (TAG),
        .byte_w (byte_w),
        .byte_x (byte_x),
        .byte_y (byte_y),
        .byte_z (byte_z)
    );

    always_comb begin
        state_d       = state_q;
        field_cnt_d   = field_cnt_q;
        sr_d          = sr_q;
        word_d        = word_q;
        out_valid_d   = out_valid_q;
        out_idx_d     = out_idx_q;
        frames_done_d = frames_done_q;

        if (clr) begin
            // Abort wins over both handshakes; completed-frame count is kept.
            state_d     = COLLECT;
            field_cnt_d = 3'd0;
            out_valid_d = 1'b0;
            out_idx_d   = 2'd0;
        end else begin
            case (state_q)
                COLLECT: begin
                    if (in_valid) begin
                        sr_d = {sr_q[SR_W-FIELD_W-1:0], in_field};
                        if (field_cnt_q == 3'(NFIELDS - 1)) begin
                            word_d      = {byte_w, byte_x, byte_y, byte_z};
                            field_cnt_d = 3'd0;
                            state_d     = EMIT;
                            out_idx_d   = 2'd0;
                            out_valid_d = 1'b1;
                        end else begin
                            field_cnt_d = field_cnt_q + 3'd1;
                        end
                    end
                end
                EMIT: begin
                    if (out_valid_q && out_ready) begin
                        out_idx_d = out_idx_q + 2'd1;
                        if (out_idx_q == 2'd3) begin
                            out_valid_d   = 1'b0;
                            state_d       = COLLECT;
                            frames_done_d = frames_done_q + CNT_W'(1);
                        end
                    end
                end
                default: state_d = COLLECT;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q       <= COLLECT;
            field_cnt_q   <= 3'd0;
            sr_q          <= '0;
            word_q        <= '0;
            out_valid_q   <= 1'b0;
            out_idx_q     <= 2'd0;
            frames_done_q <= '0;
        end else begin
            state_q       <= state_d;
            field_cnt_q   <= field_cnt_d;
            sr_q          <= sr_d;
            word_q        <= word_d;
            out_valid_q   <= out_valid_d;
            out_idx_q     <= out_idx_d;
            frames_done_q <= frames_done_d;
        end
    end

    // Byte select straight from the registered word: stable under back-pressure
    // and zero immediately on reset.
    always_comb begin
        out_byte = word_q[31:24];
        case (out_idx_q)
            2'd0:    out_byte = word_q[31:24];
            2'd1:    out_byte = word_q[23:16];
            2'd2:    out_byte = word_q[15:8];
            default: out_byte = word_q[7:0];
        endcase
    end

    assign in_ready    = (state_q == COLLECT);
    assign out_valid   = out_valid_q;
    assign out_idx     = out_idx_q;
    assign out_last    = out_valid_q && (out_idx_q == 2'd3);
    assign frames_done = frames_done_q;
    assign busy        = (field_cnt_q != 3'd0) || (state_q == EMIT);

endmodule

// File: tb/tb_field_pack_sequencer.sv
// -----------------------------------------------------------------------------
// tb_field_pack_sequencer
// Directed bench for field_pack_sequencer. Two instances share all inputs: the
// default one (8-bit frame counter) and one with a 2-bit counter to see wrap.
// -----------------------------------------------------------------------------
module tb_field_pack_sequencer;

    logic       clk = 1'b0;
    logic       resetn;
    logic       clr;
    logic       in_valid;
    logic [4:0] in_field;
    logic       out_ready;

    logic       in_ready, out_valid, out_last, busy;
    logic [7:0] out_byte;
    logic [1:0] out_idx;
    logic [7:0] frames_done;

    logic       in_ready2, out_valid2, out_last2, busy2;
    logic [7:0] out_byte2;
    logic [1:0] out_idx2;
    logic [1:0] frames_done2;

    int n_cmp = 0;
    int n_bad = 0;
    int exp_frames = 0;

    always #5 clk = ~clk;

    field_pack_sequencer dut (
        .clk         (clk),
        .resetn      (resetn),
        .clr         (clr),
        .in_valid    (in_valid),
        .in_field    (in_field),
        .in_ready    (in_ready),
        .out_valid   (out_valid),
        .out_byte    (out_byte),
        .out_idx     (out_idx),
        .out_last    (out_last),
        .out_ready   (out_ready),
        .frames_done (frames_done),
        .busy        (busy)
    );

    field_pack_sequencer #(.TAG(2'b11), .CNT_W(2)) dut2 (
        .clk         (clk),
        .resetn      (resetn),
        .clr         (clr),
        .in_valid    (in_valid),
        .in_field    (in_field),
        .in_ready    (in_ready2),
        .out_valid   (out_valid2),
        .out_byte    (out_byte2),
        .out_idx     (out_idx2),
        .out_last    (out_last2),
        .out_ready   (out_ready),
        .frames_done (frames_done2),
        .busy        (busy2)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        resetn = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        exp_frames = 0;
        step();
    endtask

    // Offer the first n fields of fv (MSB field first), one per cycle.
    task automatic push_fields(input logic [29:0] fv, input int n);
        for (int i = 0; i < n; i++) begin
            in_field = fv[29-5*i -: 5];
            in_valid = 1'b1;
            step();
        end
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        clr = 1'b0; in_valid = 1'b0; in_field = 5'd0; out_ready = 1'b0;
        @(negedge clk);
        resetn = 1'b0;
        #1;
        n_cmp++;
        if (out_valid !== 1'b0 || out_byte !== 8'h00 || out_idx !== 2'd0 || out_last !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_outputs: valid=%b byte=%h idx=%0d last=%b, want 0 00 0 0",
                     out_valid, out_byte, out_idx, out_last);
        end
        n_cmp++;
        if (frames_done !== 8'd0 || frames_done2 !== 2'd0 || in_ready !== 1'b1 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_ctrl: frames=%0d/%0d in_ready=%b busy=%b, want 0/0 1 0",
                     frames_done, frames_done2, in_ready, busy);
        end
        @(negedge clk);
        resetn = 1'b1;
        exp_frames = 0;
        step();
    endtask

    task automatic test_frame(input string name, input logic [29:0] fv, input logic [31:0] eb);
        push_fields(fv, 6);
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (out_valid !== 1'b1 || out_byte !== eb[31-8*i -: 8] || out_idx !== 2'(i)
                || out_last !== (i == 3)) begin
                n_bad++;
                $display("FAIL %s_byte%0d: valid=%b byte=%h idx=%0d last=%b, want 1 %h %0d %b",
                         name, i, out_valid, out_byte, out_idx, out_last, eb[31-8*i -: 8], i, (i == 3));
            end
            n_cmp++;
            if (in_ready !== 1'b0) begin
                n_bad++;
                $display("FAIL %s_in_ready_emit%0d: got %b want 0", name, i, in_ready);
            end
            out_ready = 1'b1;
            step();
        end
        out_ready = 1'b0;
        exp_frames++;
        n_cmp++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL %s_after: valid=%b in_ready=%b busy=%b, want 0 1 0",
                     name, out_valid, in_ready, busy);
        end
        n_cmp++;
        if (frames_done !== exp_frames[7:0] || frames_done2 !== exp_frames[1:0]) begin
            n_bad++;
            $display("FAIL %s_frames: got %0d/%0d want %0d/%0d",
                     name, frames_done, frames_done2, exp_frames[7:0], exp_frames[1:0]);
        end
    endtask

    task automatic test_backpressure();
        push_fields({5'h1F, 5'h00, 5'h1F, 5'h00, 5'h1F, 5'h00}, 6);
        n_cmp++;
        if (out_valid !== 1'b1 || out_byte !== 8'hF8) begin
            n_bad++;
            $display("FAIL bp_w: valid=%b byte=%h want 1 f8", out_valid, out_byte);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            in_valid = 1'b1;
            in_field = 5'h1F;
            n_cmp++;
            if (out_valid !== 1'b1 || out_byte !== 8'h3E || out_idx !== 2'd1 || in_ready !== 1'b0) begin
                n_bad++;
                $display("FAIL bp_hold%0d: valid=%b byte=%h idx=%0d in_ready=%b, want 1 3e 1 0",
                         c, out_valid, out_byte, out_idx, in_ready);
            end
            step();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int i = 1; i < 4; i++) begin
            logic [31:0] eb;
            eb = 32'hF83E0F83;
            n_cmp++;
            if (out_valid !== 1'b1 || out_byte !== eb[31-8*i -: 8] || out_idx !== 2'(i)) begin
                n_bad++;
                $display("FAIL bp_drain%0d: valid=%b byte=%h idx=%0d want 1 %h %0d",
                         i, out_valid, out_byte, out_idx, eb[31-8*i -: 8], i);
            end
            step();
        end
        out_ready = 1'b0;
        exp_frames++;
        n_cmp++;
        if (busy !== 1'b0 || in_ready !== 1'b1 || frames_done !== exp_frames[7:0]) begin
            n_bad++;
            $display("FAIL bp_after: busy=%b in_ready=%b frames=%0d, want 0 1 %0d",
                     busy, in_ready, frames_done, exp_frames[7:0]);
        end
    endtask

    task automatic test_clr();
        push_fields({5'h01, 5'h02, 5'h03, 5'h00, 5'h00, 5'h00}, 3);
        n_cmp++;
        if (busy !== 1'b1) begin
            n_bad++;
            $display("FAIL clr_partial_busy: got %b want 1", busy);
        end
        clr = 1'b1;
        step();
        clr = 1'b0;
        n_cmp++;
        if (busy !== 1'b0 || in_ready !== 1'b1 || frames_done !== exp_frames[7:0]) begin
            n_bad++;
            $display("FAIL clr_partial: busy=%b in_ready=%b frames=%0d, want 0 1 %0d",
                     busy, in_ready, frames_done, exp_frames[7:0]);
        end
        test_frame("clr_refill", {5'h1F, 5'h00, 5'h1F, 5'h00, 5'h1F, 5'h00}, 32'hF83E0F83);

        // Abort during EMIT while a handshake is also offered.
        push_fields({5'h1F, 5'h00, 5'h1F, 5'h00, 5'h1F, 5'h00}, 6);
        out_ready = 1'b1;
        step();
        step();
        n_cmp++;
        if (out_idx !== 2'd2 || out_byte !== 8'h0F) begin
            n_bad++;
            $display("FAIL clr_emit_pre: idx=%0d byte=%h want 2 0f", out_idx, out_byte);
        end
        clr = 1'b1;
        step();
        clr = 1'b0;
        out_ready = 1'b0;
        n_cmp++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_idx !== 2'd0 || out_last !== 1'b0) begin
            n_bad++;
            $display("FAIL clr_emit: valid=%b in_ready=%b idx=%0d last=%b, want 0 1 0 0",
                     out_valid, in_ready, out_idx, out_last);
        end
        n_cmp++;
        if (frames_done !== exp_frames[7:0] || frames_done2 !== exp_frames[1:0]) begin
            n_bad++;
            $display("FAIL clr_emit_frames: got %0d/%0d want %0d/%0d",
                     frames_done, frames_done2, exp_frames[7:0], exp_frames[1:0]);
        end

        // A field offered together with clr is dropped.
        clr = 1'b1;
        in_valid = 1'b1;
        in_field = 5'h15;
        step();
        clr = 1'b0;
        in_valid = 1'b0;
        n_cmp++;
        if (busy !== 1'b0) begin
            n_bad++;
            $display("FAIL clr_with_field: busy=%b want 0", busy);
        end
    endtask

    task automatic test_reset_mid_emit();
        push_fields({5'h1F, 5'h00, 5'h1F, 5'h00, 5'h1F, 5'h00}, 6);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        #2;
        resetn = 1'b0;
        exp_frames = 0;
        #1;
        n_cmp++;
        if (out_valid !== 1'b0 || out_byte !== 8'h00 || out_idx !== 2'd0) begin
            n_bad++;
            $display("FAIL rst_mid_emit: valid=%b byte=%h idx=%0d, want 0 00 0",
                     out_valid, out_byte, out_idx);
        end
        n_cmp++;
        if (frames_done !== 8'd0 || frames_done2 !== 2'd0 || in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL rst_mid_emit_ctrl: frames=%0d/%0d in_ready=%b, want 0/0 1",
                     frames_done, frames_done2, in_ready);
        end
        #1;
        resetn = 1'b1;
        step();
        test_frame("post_reset", {5'h00, 5'h00, 5'h00, 5'h00, 5'h00, 5'h01}, 32'h00000007);
    endtask

    task automatic test_back_to_back();
        logic [29:0] fv;
        logic [31:0] eb;
        fv = {5'h1F, 5'h00, 5'h1F, 5'h00, 5'h1F, 5'h00};
        eb = 32'hF83E0F83;
        do_reset();
        out_ready = 1'b1;
        in_valid = 1'b1;
        for (int f = 0; f < 5; f++) begin
            for (int c = 0; c < 10; c++) begin
                if (c < 6) in_field = fv[29-5*c -: 5];
                n_cmp++;
                if (in_ready !== (c < 6)) begin
                    n_bad++;
                    $display("FAIL b2b_in_ready f%0d c%0d: got %b want %b", f, c, in_ready, (c < 6));
                end
                if (c >= 6) begin
                    n_cmp++;
                    if (out_valid !== 1'b1 || out_byte !== eb[31-8*(c-6) -: 8] || out_last !== (c == 9)) begin
                        n_bad++;
                        $display("FAIL b2b_byte f%0d c%0d: valid=%b byte=%h last=%b want 1 %h %b",
                                 f, c, out_valid, out_byte, out_last, eb[31-8*(c-6) -: 8], (c == 9));
                    end
                end
                step();
            end
            exp_frames++;
            n_cmp++;
            if (frames_done !== exp_frames[7:0] || frames_done2 !== exp_frames[1:0]) begin
                n_bad++;
                $display("FAIL b2b_frames f%0d: got %0d/%0d want %0d/%0d",
                         f, frames_done, frames_done2, exp_frames[7:0], exp_frames[1:0]);
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b0;
    endtask

    initial begin
        resetn = 1'b1;
        test_reset();
        test_frame("zeros", {5'h00, 5'h00, 5'h00, 5'h00, 5'h00, 5'h00}, 32'h00000003);
        test_frame("alt",   {5'h1F, 5'h00, 5'h1F, 5'h00, 5'h1F, 5'h00}, 32'hF83E0F83);
        test_frame("one",   {5'h00, 5'h00, 5'h00, 5'h00, 5'h00, 5'h01}, 32'h00000007);
        test_backpressure();
        test_clr();
        test_reset_mid_emit();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
